demux1_4_sched: RTL

Round-robin scheduler that sequences the shared 1-to-4 demultiplexer datapath. It accepts one word at a time from a single upstream source and steers it to one of four downstream consumers. The consumer is chosen by round-robin priority, skipping consumers that are not ready. It drives the demux select, a one-hot per-channel valid and the shared data bus, and sits between the input stream and the four output channels.

---
 rtl/demux1_4_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/demux1_4_sched.sv
// demux1_4_sched: round-robin scheduler for a shared 1-to-4 demux datapath.
// Define DEMUX_SCHED_TIMEOUT_EN to enable the SEND timeout abort and drop pulse.
module demux1_4_sched #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       out_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic [15:0]      xfer_cnt,
  output logic             drop
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SEND
  } state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       sel_n;
  logic [3:0]       ov_n;
  logic [WIDTH-1:0] od_n;
  logic [15:0]      cnt_n;
  logic [1:0]       pick, idx;
  logic             found;
  logic             hs;
  logic             tmo;

  assign in_ready = (state == IDLE);
  assign hs = (state == SEND) && out_valid[sel] && out_ready[sel];

  // First ready channel starting from the priority pointer.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && out_ready[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic [7:0] tcnt, tcnt_n;
  logic       drop_q;

  assign tmo  = (state == SEND) && !hs &&
                ((tcnt + 8'd1) == 8'(TIMEOUT));
  assign drop = drop_q;

  always_comb begin
    tcnt_n = tcnt;
    if (state == ARB && found)
      tcnt_n = 8'd0;
    else if (state == SEND && !hs)
      tcnt_n = tcnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt   <= 8'd0;
      drop_q <= 1'b0;
    end else begin
      tcnt   <= tcnt_n;
      drop_q <= tmo;
    end
  end
`else
  assign tmo  = 1'b0;
  assign drop = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    ov_n    = out_valid;
    od_n    = out_data;
    cnt_n   = xfer_cnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          od_n    = in_data;
          state_n = ARB;
        end
      end
      ARB: begin
        if (found) begin
          sel_n   = pick;
          ov_n    = 4'b0001 << pick;
          state_n = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          ov_n    = 4'b0000;
          ptr_n   = sel + 2'd1;
          cnt_n   = xfer_cnt + 16'd1;
          state_n = IDLE;
        end else if (tmo) begin
          ov_n    = 4'b0000;
          ptr_n   = sel + 2'd1;
          state_n = IDLE;
        end
      end
      default: begin
        ov_n    = 4'b0000;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      out_valid <= 4'b0000;
      out_data  <= '0;
      xfer_cnt  <= 16'd0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      out_valid <= ov_n;
      out_data  <= od_n;
      xfer_cnt  <= cnt_n;
    end
  end

endmodule
